// File: rtl/attr_sweep_pkg.sv
// Shared encodings for the attractor sweep: result kinds and sequencer states.
package attr_pkg;

    localparam logic [1:0] KIND_NONE    = 2'd0;
    localparam logic [1:0] KIND_FIX     = 2'd1;
    localparam logic [1:0] KIND_CYCLE   = 2'd2;
    localparam logic [1:0] KIND_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESTART,
        ST_RUN,
        ST_RECORD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/attr_tally.sv
// Three N+1-bit result tallies (fix, cycle, timeout) with synchronous clear
// and one-hot increment; the timeout tally can be tied off to zero.
module attr_tally
    import attr_pkg::*;
#(
    parameter int N           = 8,
    parameter bit HAS_TIMEOUT = 1'b1
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         clr,
    input  logic [2:0]   inc,
    output logic [N:0]   fix_cnt,
    output logic [N:0]   cycle_cnt,
    output logic [N:0]   timeout_cnt
);

    logic [N:0] cnt [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            if (gi == 2 && !HAS_TIMEOUT) begin : g_tied
                logic unused_inc;
                assign unused_inc = inc[gi];
                assign cnt[gi]    = '0;
            end else begin : g_live
                logic [N:0] cnt_reg;
                always_ff @(posedge clk or negedge n_reset) begin
                    if (!n_reset) begin
                        cnt_reg <= '0;
                    end else if (clr) begin
                        cnt_reg <= '0;
                    end else if (inc[gi]) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                assign cnt[gi] = cnt_reg;
            end
        end
    endgenerate

    assign fix_cnt     = cnt[0];
    assign cycle_cnt   = cnt[1];
    assign timeout_cnt = cnt[2];

endmodule

// File: rtl/attr_sweep.sv
// Sweep sequencer: restarts the gene network from every initial state and
// classifies each trajectory. Define ATTR_SWEEP_TIMEOUT_EN to enable run timeout.
module attr_sweep
    import attr_pkg::*;
#(
    parameter int N         = 8,
    parameter int RST_CYC   = 2,
    parameter int MAX_STEPS = 64
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         start,
    output logic [N-1:0] x_init,
    output logic         net_n_reset,
    input  logic         cycle,
    input  logic         fix,
    output logic         busy,
    output logic         done,
    output logic         res_valid,
    output logic [N-1:0] res_x,
    output logic [1:0]   res_kind,
    output logic [7:0]   res_steps,
    output logic [N:0]   fix_cnt,
    output logic [N:0]   cycle_cnt,
    output logic [N:0]   timeout_cnt
);

`ifdef ATTR_SWEEP_TIMEOUT_EN
    localparam bit HAS_TIMEOUT = 1'b1;
`else
    localparam bit HAS_TIMEOUT = 1'b0;
`endif

    localparam int         RCW       = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [7:0] LAST_STEP = 8'(MAX_STEPS - 1);

    state_t         state_reg;
    logic [N-1:0]   x_init_reg;
    logic           net_n_reset_reg;
    logic [RCW-1:0] rst_cnt_reg;
    logic [7:0]     steps_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           res_valid_reg;
    logic [N-1:0]   res_x_reg;
    logic [1:0]     res_kind_reg;
    logic [7:0]     res_steps_reg;

    logic [1:0]     run_kind;
    logic           tally_clr;
    logic [2:0]     tally_inc;

    // fix outranks cycle; timeout only when neither checker has fired
    always_comb begin
        run_kind = KIND_NONE;
        if (fix) begin
            run_kind = KIND_FIX;
        end else if (cycle) begin
            run_kind = KIND_CYCLE;
        end else if (HAS_TIMEOUT && (steps_reg == LAST_STEP)) begin
            run_kind = KIND_TIMEOUT;
        end
    end

    assign tally_clr = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign tally_inc = (state_reg == ST_RECORD) ?
                       {res_kind_reg == KIND_TIMEOUT,
                        res_kind_reg == KIND_CYCLE,
                        res_kind_reg == KIND_FIX} : 3'b000;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg       <= ST_IDLE;
            x_init_reg      <= '0;
            net_n_reset_reg <= 1'b0;
            rst_cnt_reg     <= '0;
            steps_reg       <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            res_valid_reg   <= 1'b0;
            res_x_reg       <= '0;
            res_kind_reg    <= KIND_NONE;
            res_steps_reg   <= '0;
        end else begin
            res_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg       <= ST_RESTART;
                        x_init_reg      <= '0;
                        rst_cnt_reg     <= '0;
                        net_n_reset_reg <= 1'b0;
                        busy_reg        <= 1'b1;
                        done_reg        <= 1'b0;
                    end
                end
                ST_RESTART: begin
                    if (rst_cnt_reg == RCW'(RST_CYC - 1)) begin
                        state_reg       <= ST_RUN;
                        net_n_reset_reg <= 1'b1;
                        steps_reg       <= '0;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_kind != KIND_NONE) begin
                        state_reg       <= ST_RECORD;
                        net_n_reset_reg <= 1'b0;
                        res_valid_reg   <= 1'b1;
                        res_x_reg       <= x_init_reg;
                        res_kind_reg    <= run_kind;
                        res_steps_reg   <= steps_reg;
                    end else if (steps_reg != 8'hFF) begin
                        // saturate so an endless run never aliases a short one
                        steps_reg <= steps_reg + 8'd1;
                    end
                end
                ST_RECORD: begin
                    if (x_init_reg == '1) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg   <= ST_RESTART;
                        x_init_reg  <= x_init_reg + 1'b1;
                        rst_cnt_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    attr_tally #(
        .N           (N),
        .HAS_TIMEOUT (HAS_TIMEOUT)
    ) u_tally (
        .clk         (clk),
        .n_reset     (n_reset),
        .clr         (tally_clr),
        .inc         (tally_inc),
        .fix_cnt     (fix_cnt),
        .cycle_cnt   (cycle_cnt),
        .timeout_cnt (timeout_cnt)
    );

    assign x_init      = x_init_reg;
    assign net_n_reset = net_n_reset_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign res_valid   = res_valid_reg;
    assign res_x       = res_x_reg;
    assign res_kind    = res_kind_reg;
    assign res_steps   = res_steps_reg;

endmodule

// File: tb/tb_attr_sweep.sv
// Directed bench for attr_sweep; checker stubs fire after x_init%4 run cycles.
module tb_attr_sweep;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x_init;
    logic       net_n_reset;
    logic       cycle;
    logic       fix;
    logic       busy;
    logic       done;
    logic       res_valid;
    logic [7:0] res_x;
    logic [1:0] res_kind;
    logic [7:0] res_steps;
    logic [8:0] fix_cnt;
    logic [8:0] cycle_cnt;
    logic [8:0] timeout_cnt;

    int checks = 0;
    int failures = 0;
    bit fix_en = 1'b0;
    bit cyc_en = 1'b0;
    logic [7:0] rc = 8'd0;

    always #5 clk = ~clk;

    // run-cycle counter mirroring how long the network has been out of reset
    always @(posedge clk) rc <= net_n_reset ? rc + 8'd1 : 8'd0;

    assign fix   = fix_en && net_n_reset && (rc == {6'd0, x_init[1:0]});
    assign cycle = cyc_en && net_n_reset && (rc == {6'd0, x_init[1:0]});

    attr_sweep dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .start       (start),
        .x_init      (x_init),
        .net_n_reset (net_n_reset),
        .cycle       (cycle),
        .fix         (fix),
        .busy        (busy),
        .done        (done),
        .res_valid   (res_valid),
        .res_x       (res_x),
        .res_kind    (res_kind),
        .res_steps   (res_steps),
        .fix_cnt     (fix_cnt),
        .cycle_cnt   (cycle_cnt),
        .timeout_cnt (timeout_cnt)
    );

    task automatic do_start;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_result(input int budget, output bit got, output int waited);
        got = 1'b0;
        waited = 0;
        while (!got && waited < budget) begin
            @(posedge clk);
            #1;
            waited++;
            got = res_valid;
        end
    endtask

    task automatic test_reset;
        n_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy, done, res_valid, net_n_reset} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b want=0000", {busy, done, res_valid, net_n_reset}); end
        checks++; if ({x_init, res_x, res_kind, res_steps} !== 26'd0) begin failures++; $display("FAIL reset_data got=%h want=0", {x_init, res_x, res_kind, res_steps}); end
        checks++; if ({fix_cnt, cycle_cnt, timeout_cnt} !== 27'd0) begin failures++; $display("FAIL reset_tallies got=%h want=0", {fix_cnt, cycle_cnt, timeout_cnt}); end
        @(negedge clk) n_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({busy, net_n_reset} !== 2'b00) begin failures++; $display("FAIL idle_hold got=%b want=00", {busy, net_n_reset}); end
    endtask

    task automatic test_fix_sweep;
        bit got;
        int w;
        int exp_w;
        fix_en = 1'b1; cyc_en = 1'b0;
        do_start();
        for (int k = 0; k < 256; k++) begin
            wait_result(100, got, w);
            checks++; if (!got) begin failures++; $display("FAIL fix_sweep_wait x=%0d got=none want=res_valid", k); break; end
            exp_w = ((k == 0) ? 3 : 4) + (k % 4);
            $display("fix_sweep x=%0d kind=%0d steps=%0d interval=%0d", res_x, res_kind, res_steps, w);
            checks++; if (res_x !== k[7:0]) begin failures++; $display("FAIL fix_res_x got=%0d want=%0d", res_x, k); end
            checks++; if (res_kind !== 2'd1) begin failures++; $display("FAIL fix_res_kind got=%0d want=1", res_kind); end
            checks++; if (res_steps !== 8'(k % 4)) begin failures++; $display("FAIL fix_res_steps got=%0d want=%0d", res_steps, k % 4); end
            checks++; if (w !== exp_w) begin failures++; $display("FAIL fix_interval x=%0d got=%0d want=%0d", k, w, exp_w); end
            checks++; if (fix_cnt !== 9'(k)) begin failures++; $display("FAIL fix_running_cnt got=%0d want=%0d", fix_cnt, k); end
        end
        @(posedge clk);
        #1;
        checks++; if ({done, busy} !== 2'b10) begin failures++; $display("FAIL fix_done_flags got=%b want=10", {done, busy}); end
        checks++; if (fix_cnt !== 9'd256) begin failures++; $display("FAIL fix_cnt_final got=%0d want=256", fix_cnt); end
        checks++; if ({cycle_cnt, timeout_cnt} !== 18'd0) begin failures++; $display("FAIL fix_other_cnt got=%0d/%0d want=0/0", cycle_cnt, timeout_cnt); end
    endtask

    task automatic test_cycle_sweep;
        bit got;
        int w;
        fix_en = 1'b0; cyc_en = 1'b1;
        do_start();
        for (int k = 0; k < 256; k++) begin
            wait_result(100, got, w);
            checks++; if (!got) begin failures++; $display("FAIL cycle_sweep_wait x=%0d got=none want=res_valid", k); break; end
            $display("cycle_sweep x=%0d kind=%0d steps=%0d", res_x, res_kind, res_steps);
            checks++; if ({res_x, res_kind} !== {k[7:0], 2'd2}) begin failures++; $display("FAIL cycle_result got=%0d/%0d want=%0d/2", res_x, res_kind, k); end
        end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL cycle_done got=%b want=1", done); end
        checks++; if ({fix_cnt, cycle_cnt, timeout_cnt} !== {9'd0, 9'd256, 9'd0}) begin failures++; $display("FAIL cycle_tallies got=%0d/%0d/%0d want=0/256/0", fix_cnt, cycle_cnt, timeout_cnt); end
    endtask

    task automatic test_priority;
        bit got;
        int w;
        fix_en = 1'b1; cyc_en = 1'b1;
        do_start();
        for (int k = 0; k < 256; k++) begin
            wait_result(100, got, w);
            checks++; if (!got) begin failures++; $display("FAIL prio_wait x=%0d got=none want=res_valid", k); break; end
            $display("priority x=%0d kind=%0d steps=%0d", res_x, res_kind, res_steps);
            checks++; if (res_kind !== 2'd1) begin failures++; $display("FAIL prio_kind x=%0d got=%0d want=1", k, res_kind); end
        end
        @(posedge clk);
        #1;
        checks++; if ({fix_cnt, cycle_cnt} !== {9'd256, 9'd0}) begin failures++; $display("FAIL prio_tallies got=%0d/%0d want=256/0", fix_cnt, cycle_cnt); end
    endtask

    task automatic test_timeout;
        bit got;
        int w;
        fix_en = 1'b0; cyc_en = 1'b0;
        do_start();
`ifdef ATTR_SWEEP_TIMEOUT_EN
        for (int k = 0; k < 256; k++) begin
            wait_result(200, got, w);
            checks++; if (!got) begin failures++; $display("FAIL timeout_wait x=%0d got=none want=res_valid", k); break; end
            $display("timeout x=%0d kind=%0d steps=%0d interval=%0d", res_x, res_kind, res_steps, w);
            checks++; if ({res_x, res_kind, res_steps} !== {k[7:0], 2'd3, 8'd63}) begin failures++; $display("FAIL timeout_result got=%0d/%0d/%0d want=%0d/3/63", res_x, res_kind, res_steps, k); end
            checks++; if (w !== ((k == 0) ? 66 : 67)) begin failures++; $display("FAIL timeout_interval got=%0d want=%0d", w, (k == 0) ? 66 : 67); end
        end
        @(posedge clk);
        #1;
        checks++; if ({fix_cnt, cycle_cnt, timeout_cnt} !== {9'd0, 9'd0, 9'd256}) begin failures++; $display("FAIL timeout_tallies got=%0d/%0d/%0d want=0/0/256", fix_cnt, cycle_cnt, timeout_cnt); end
`else
        wait_result(300, got, w);
        $display("no_timeout waited=%0d busy=%b timeout_cnt=%0d", w, busy, timeout_cnt);
        checks++; if (got !== 1'b0) begin failures++; $display("FAIL no_timeout_result got=kind%0d want=none", res_kind); end
        checks++; if ({busy, net_n_reset, timeout_cnt} !== {2'b11, 9'd0}) begin failures++; $display("FAIL no_timeout_state got=%b%b/%0d want=11/0", busy, net_n_reset, timeout_cnt); end
        @(negedge clk) n_reset = 1'b0;
        @(negedge clk) n_reset = 1'b1;
`endif
    endtask

    task automatic test_midreset;
        bit got;
        int w;
        int n;
        fix_en = 1'b1; cyc_en = 1'b0;
        do_start();
        n = 0;
        while (!(x_init == 8'd5 && net_n_reset) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n >= 200) begin failures++; $display("FAIL midreset_reach got=x%0d want=x5_run", x_init); end
        #2 n_reset = 1'b0;
        #1;
        $display("midreset asserted x_init=%0d busy=%b", x_init, busy);
        checks++; if ({busy, done, res_valid, net_n_reset, x_init, fix_cnt} !== 21'd0) begin failures++; $display("FAIL midreset_async got=%h want=0", {busy, done, res_valid, net_n_reset, x_init, fix_cnt}); end
        checks++; if ({res_x, res_kind, res_steps} !== 18'd0) begin failures++; $display("FAIL midreset_result got=%h want=0", {res_x, res_kind, res_steps}); end
        @(posedge clk);
        #1;
        checks++; if ({busy, net_n_reset, x_init} !== 10'd0) begin failures++; $display("FAIL midreset_hold got=%h want=0", {busy, net_n_reset, x_init}); end
        @(negedge clk) n_reset = 1'b1;
        do_start();
        wait_result(100, got, w);
        $display("midreset restart x=%0d kind=%0d", res_x, res_kind);
        checks++; if ({got, res_x} !== {1'b1, 8'd0}) begin failures++; $display("FAIL midreset_restart got=%b/%0d want=1/0", got, res_x); end
        @(negedge clk) n_reset = 1'b0;
        @(negedge clk) n_reset = 1'b1;
    endtask

    task automatic test_back_to_back;
        bit got;
        int w;
        fix_en = 1'b1; cyc_en = 1'b0;
        do_start();
        for (int k = 0; k < 256; k++) begin
            if (k == 3) begin
                @(negedge clk) start = 1'b1;
                @(negedge clk) start = 1'b0;
            end
            wait_result(100, got, w);
            checks++; if (!got) begin failures++; $display("FAIL busy_start_wait x=%0d got=none want=res_valid", k); break; end
            if (k < 5) $display("busy_start x=%0d kind=%0d fix_cnt=%0d", res_x, res_kind, fix_cnt);
            checks++; if (res_x !== k[7:0]) begin failures++; $display("FAIL busy_start_x got=%0d want=%0d", res_x, k); end
            if (k == 3) begin
                checks++; if (fix_cnt !== 9'd3) begin failures++; $display("FAIL busy_start_noclr got=%0d want=3", fix_cnt); end
            end
        end
        @(posedge clk);
        #1;
        checks++; if ({done, fix_cnt} !== {1'b1, 9'd256}) begin failures++; $display("FAIL busy_start_done got=%b/%0d want=1/256", done, fix_cnt); end
        do_start();
        $display("restart_from_done fix_cnt=%0d busy=%b x_init=%0d", fix_cnt, busy, x_init);
        checks++; if ({busy, done, x_init, fix_cnt} !== {2'b10, 8'd0, 9'd0}) begin failures++; $display("FAIL done_restart got=%b%b/%0d/%0d want=10/0/0", busy, done, x_init, fix_cnt); end
    endtask

    initial begin
        test_reset();
        test_fix_sweep();
        test_cycle_sweep();
        test_priority();
        test_timeout();
        test_midreset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
